// File: rtl/cmd_frame_queue_pkg.sv
// Shared types and constants for the vertical-blank command queue.
// An opcode of zero is a NOP and is never stored or issued.
package cmd_frame_queue_pkg;

    localparam int CMD_W = 32;
    localparam logic [CMD_W-1:0] OP_NOP = '0;

    typedef struct packed {
        logic [CMD_W-1:0] op;
        logic [CMD_W-1:0] dat;
    } cmd_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

endpackage

// File: rtl/cmd_frame_queue_fifo.sv
// Generic synchronous FIFO: registered level, zero-latency head read, synchronous flush.
// Latency: a push is visible at the head the next cycle; backpressure: pushes ignored when full, pops ignored when empty.
module cmd_frame_queue_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_push_dat,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output logic [WIDTH-1:0]       o_head_dat,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push & ~o_full  & ~i_flush;
    assign w_pop  = i_pop  & ~o_empty & ~i_flush;

    always_ff @(posedge i_clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (AW + 1)'(1);
                2'b01:   r_level <= r_level - (AW + 1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_full     = (r_level == DEPTH_C);
    assign o_empty    = (r_level == '0);
    assign o_level    = r_level;

endmodule

// File: rtl/cmd_frame_queue.sv
// Queues processor commands and replays them to compute only inside vertical blank.
// Latency: first issue 1 cycle after the vsync edge is seen, then every ISSUE_GAP; backpressure: o_wr_ready low when full or flushing.
module cmd_frame_queue
    import cmd_frame_queue_pkg::*;
#(
    parameter int DEPTH         = 16,
    parameter int MAX_PER_FRAME = 64,
    parameter int ISSUE_GAP     = 1
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_wr_valid,
    output logic                   o_wr_ready,
    input  logic [CMD_W-1:0]       i_wr_operation,
    input  logic [CMD_W-1:0]       i_wr_data,
    input  logic                   i_flush,
    input  logic                   i_vsync,
    output logic [CMD_W-1:0]       o_operation,
    output logic [CMD_W-1:0]       o_data,
    output logic                   o_issue,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_frame_done
);

    localparam int CW = $clog2(MAX_PER_FRAME + 1);
    localparam int GW = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
    localparam logic [CW-1:0] MAX_C      = CW'(MAX_PER_FRAME);
    localparam logic [GW-1:0] GAP_RELOAD = GW'(ISSUE_GAP - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_vs_s1;
    logic             r_vs_s2;
    logic             r_vs_d;
    logic             r_rdy_en;
    logic [CW-1:0]    r_issued;
    logic [GW-1:0]    r_gap;
    logic [CMD_W-1:0] r_operation;
    logic [CMD_W-1:0] r_data;
    logic             r_issue;
    logic             r_frame_done;
    logic             w_vs_fall;
    logic             w_start;
    logic             w_exit;
    logic             w_pop;
    logic             w_push;
    logic             w_full;
    logic             w_empty;
    cmd_t             w_head;
    cmd_t             w_wr_cmd;

    assign w_vs_fall  = r_vs_d & ~r_vs_s2;
    assign o_wr_ready = r_rdy_en & ~w_full & ~i_flush;
    assign w_push     = i_wr_valid & o_wr_ready & (i_wr_operation != OP_NOP);
    assign w_wr_cmd   = {i_wr_operation, i_wr_data};

    cmd_frame_queue_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_push     (w_push),
        .i_push_dat (w_wr_cmd),
        .i_pop      (w_pop),
        .i_flush    (i_flush),
        .o_head_dat (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_level    (o_level)
    );

    // The entry cycle may already issue, so the first command leaves one cycle after the edge.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_exit      = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_vs_fall) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_DRAIN;
                    w_pop       = ~w_empty;
                end
            end
            ST_DRAIN: begin
                if (w_empty || (r_issued == MAX_C) || r_vs_s2) begin
                    w_exit      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_pop = (r_gap == '0);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (i_flush) begin
            w_state_nxt = ST_IDLE;
            w_start     = 1'b0;
            w_exit      = 1'b0;
            w_pop       = 1'b0;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= ST_IDLE;
            r_vs_s1      <= 1'b1;
            r_vs_s2      <= 1'b1;
            r_vs_d       <= 1'b1;
            r_rdy_en     <= 1'b0;
            r_issued     <= '0;
            r_gap        <= '0;
            r_operation  <= OP_NOP;
            r_data       <= '0;
            r_issue      <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_vs_s1      <= i_vsync;
            r_vs_s2      <= r_vs_s1;
            r_vs_d       <= r_vs_s2;
            r_rdy_en     <= 1'b1;
            r_issue      <= w_pop;
            r_frame_done <= w_exit;
            r_operation  <= w_pop ? w_head.op  : OP_NOP;
            r_data       <= w_pop ? w_head.dat : '0;
            if (w_start) begin
                r_issued <= w_pop ? CW'(1) : '0;
            end else if (w_pop) begin
                r_issued <= r_issued + CW'(1);
            end
            if (w_pop) begin
                r_gap <= GAP_RELOAD;
            end else if (w_start) begin
                r_gap <= '0;
            end else if (r_gap != '0) begin
                r_gap <= r_gap - GW'(1);
            end
        end
    end

    assign o_operation  = r_operation;
    assign o_data       = r_data;
    assign o_issue      = r_issue;
    assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_cmd_frame_queue.sv
// Bench for cmd_frame_queue: directed frame scenarios then random traffic against a queue model.
module tb_cmd_frame_queue;

    localparam int D    = 16;
    localparam int MAXF = 4;
    localparam int G    = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_op;
    logic [31:0] wr_dat;
    logic        flush;
    logic        vsync;
    logic [31:0] op_out;
    logic [31:0] dat_out;
    logic        issue;
    logic [4:0]  level;
    logic        frame_done;

    cmd_frame_queue #(
        .DEPTH         (D),
        .MAX_PER_FRAME (MAXF),
        .ISSUE_GAP     (G)
    ) dut (
        .i_clock        (clk),
        .i_reset        (rst_n),
        .i_wr_valid     (wr_valid),
        .o_wr_ready     (wr_ready),
        .i_wr_operation (wr_op),
        .i_wr_data      (wr_dat),
        .i_flush        (flush),
        .i_vsync        (vsync),
        .o_operation    (op_out),
        .o_data         (dat_out),
        .o_issue        (issue),
        .o_level        (level),
        .o_frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [63:0] mq[$];
    int          iss_cyc[$];
    int          fd_cnt = 0;
    int          acc_cnt = 0;
    int          last_iss = -1000;
    bit          first = 1'b0;
    bit          pend_push = 1'b0;
    bit          pend_flush = 1'b0;
    bit          last_acc = 1'b0;
    logic [63:0] pend_cmd = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int min3(input int a, input int b, input int c);
        int m = a;
        if (b < m) m = b;
        if (c < m) m = c;
        return m;
    endfunction

    // One clock: settle model with the previous edge's events, check, then advance.
    task automatic tick();
        logic [63:0] e;
        @(negedge clk);
        if (pend_flush) begin
            check("flush_kills_issue", issue, 0);
            mq.delete();
        end else if (issue) begin
            check("issue_has_entry", mq.size() > 0, 1);
            if (mq.size() > 0) begin
                e = mq.pop_front();
                check("issue_cmd", {op_out, dat_out}, e);
            end
            check("issue_gap_ok", (cyc - last_iss) >= G, 1);
            iss_cyc.push_back(cyc);
            last_iss = cyc;
        end
        if (!issue) check("idle_outputs_zero", {op_out, dat_out}, 0);
        if (pend_push) mq.push_back(pend_cmd);
        if (frame_done) fd_cnt++;
        check("level", level, mq.size());
        check("wr_ready", wr_ready, !first && mq.size() < D && !flush);
        first      = 1'b0;
        last_acc   = wr_valid && wr_ready;
        pend_push  = last_acc && (wr_op != 0);
        pend_cmd   = {wr_op, wr_dat};
        pend_flush = flush;
        if (last_acc) acc_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] op, input logic [31:0] d);
        int g = 0;
        wr_valid = 1'b1;
        wr_op    = op;
        wr_dat   = d;
        do begin
            tick();
            g++;
        end while (!last_acc && g < 40);
        check("wr_accepted", last_acc, 1);
        wr_valid = 1'b0;
    endtask

    // Hold vsync low for L cycles; the window can issue every G cycles within those L cycles.
    task automatic drain(input int L, input string tag);
        int c0, f0, v, exp_n;
        c0    = iss_cyc.size();
        f0    = fd_cnt;
        exp_n = min3(mq.size(), MAXF, (L + G - 1) / G);
        vsync = 1'b0;
        v     = cyc;
        repeat (L) tick();
        vsync = 1'b1;
        repeat (8) tick();
        check({tag, "_issued"}, iss_cyc.size() - c0, exp_n);
        check({tag, "_frame_done"}, fd_cnt - f0, 1);
        if (exp_n > 0 && iss_cyc.size() > c0) check({tag, "_first_latency"}, iss_cyc[c0] - v, 3);
        for (int k = c0 + 1; k < iss_cyc.size(); k++) check({tag, "_spacing"}, iss_cyc[k] - iss_cyc[k-1], G);
    endtask

    task automatic wait_first_issue(input string tag);
        int c0 = iss_cyc.size();
        int g  = 0;
        while (iss_cyc.size() == c0 && g < 20) begin
            tick();
            g++;
        end
        check({tag, "_issue_seen"}, iss_cyc.size() > c0, 1);
    endtask

    initial begin
        int c, f, a, vs_left;
        rst_n = 1'b0; wr_valid = 1'b0; wr_op = '0; wr_dat = '0; flush = 1'b0; vsync = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_operation", op_out, 0);
        check("rst_data", dat_out, 0);
        check("rst_issue", issue, 0);
        check("rst_level", level, 0);
        check("rst_frame_done", frame_done, 0);
        rst_n = 1'b1;
        first = 1'b1;
        tick();
        check("ready_after_release", wr_ready, 1);

        // Three commands mid-frame stay put until the blank starts.
        wr(32'd5, 32'hA);
        wr(32'd6, 32'hB);
        wr(32'd7, 32'hC);
        c = iss_cyc.size();
        repeat (10) tick();
        check("no_issue_vsync_high", iss_cyc.size() - c, 0);
        check("three_queued", level, 3);
        drain(20, "three_cmds");

        // Fill past capacity with no blank.
        a = acc_cnt;
        wr_valid = 1'b1;
        for (int i = 0; i < D + 4; i++) begin
            wr_op  = 32'h100 + i;
            wr_dat = $urandom;
            tick();
        end
        check("full_accepts", acc_cnt - a, D);
        check("full_ready", wr_ready, 0);
        check("full_level", level, D);
        wr_valid = 1'b0;

        // Flush while idle, with a write offered the same cycle.
        flush = 1'b1; wr_valid = 1'b1; wr_op = 32'h55; wr_dat = 32'h1;
        tick();
        check("flush_blocks_write", last_acc, 0);
        flush = 1'b0; wr_valid = 1'b0;
        tick();
        check("flush_level", level, 0);

        // Per-frame cap.
        for (int i = 0; i < 10; i++) wr(32'h200 + i, $urandom);
        drain(20, "cap_a");
        check("cap_level_a", level, 6);
        drain(20, "cap_b");
        check("cap_level_b", level, 2);
        drain(20, "cap_c");

        // vsync returns high early.
        for (int i = 0; i < 5; i++) wr(32'h300 + i, $urandom);
        drain(3, "short_win");
        check("short_level", level, 3);
        drain(20, "short_rest");

        // Flush during a drain on an issue cycle.
        for (int i = 0; i < 6; i++) wr(32'h400 + i, $urandom);
        vsync = 1'b0;
        wait_first_issue("flush_drain");
        f = fd_cnt;
        c = iss_cyc.size();
        flush = 1'b1; wr_valid = 1'b1; wr_op = 32'h77; wr_dat = 32'h2;
        tick();
        check("flush_drain_write", last_acc, 0);
        flush = 1'b0; wr_valid = 1'b0;
        tick();
        check("flush_drain_issue", issue, 0);
        check("flush_drain_level", level, 0);
        vsync = 1'b1;
        repeat (8) tick();
        check("flush_drain_no_frame_done", fd_cnt - f, 0);
        check("flush_drain_no_more_issue", iss_cyc.size() - c, 0);

        // NOP write is accepted but not queued.
        wr(32'h500, 32'h3);
        wr(32'h501, 32'h4);
        wr(32'd0, 32'hDEAD);
        check("nop_level", level, 2);
        drain(20, "after_nop");

        // Reset in the middle of a drain.
        for (int i = 0; i < 4; i++) wr(32'h600 + i, $urandom);
        vsync = 1'b0;
        wait_first_issue("rst_drain");
        rst_n = 1'b0;
        vsync = 1'b1;
        #1;
        check("mid_rst_operation", op_out, 0);
        check("mid_rst_data", dat_out, 0);
        check("mid_rst_issue", issue, 0);
        check("mid_rst_level", level, 0);
        check("mid_rst_ready", wr_ready, 0);
        mq.delete();
        pend_push = 1'b0; pend_flush = 1'b0; last_iss = -1000;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        first = 1'b1;
        tick();

        // Random traffic with overlapping writes, blanks and occasional flushes.
        vs_left = 5;
        for (int i = 0; i < 600; i++) begin
            wr_valid = ($urandom_range(0, 2) != 0);
            wr_op    = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom_range(1, 32'hFFFF);
            wr_dat   = $urandom;
            flush    = ($urandom_range(0, 60) == 0);
            if (vs_left == 0) begin
                vsync   = ~vsync;
                vs_left = $urandom_range(1, 15);
            end else begin
                vs_left--;
            end
            tick();
        end
        wr_valid = 1'b0; flush = 1'b0; vsync = 1'b1;
        repeat (10) tick();
        drain(20, "final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: observed no finish, expected finish within 50000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
